// File: rtl/edge_seq_monitor_pkg.sv
// Shared types and defaults for the edge_seq_monitor block.
package edge_seq_monitor_pkg;

  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_ANY  = 2'b10,
    MODE_OFF  = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam int unsigned DEF_N_CH  = 4;
  localparam int unsigned DEF_CNT_W = 8;
  localparam int unsigned DEF_WIN_W = 4;

  // Edge qualification of the current sample against the previous one.
  function automatic logic edge_hit(input mode_e m, input logic cur, input logic prev);
    logic hit;
    hit = 1'b0;
    case (m)
      MODE_RISE: hit = cur & ~prev;
      MODE_FALL: hit = ~cur & prev;
      MODE_ANY:  hit = cur ^ prev;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/edge_seq_monitor_ch.sv
// One monitor channel: history flop, edge detect, IDLE/WAIT window FSM,
// window timer and saturating edge counter.
// EDGE_SEQ_MONITOR_SYNC_EN: when defined, a and b pass through two-flop
// synchronisers before use.
import edge_seq_monitor_pkg::*;

module edge_seq_monitor_ch #(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned WIN_W = DEF_WIN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIN_W-1:0] win,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  output logic             edge_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic a_use;
  logic b_use;

`ifdef EDGE_SEQ_MONITOR_SYNC_EN
  logic [1:0] a_sync;
  logic [1:0] b_sync;

  // Two-flop synchronisers for the asynchronous channel inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sync <= '0;
      b_sync <= '0;
    end else begin
      a_sync <= {a_sync[0], a};
      b_sync <= {b_sync[0], b};
    end
  end

  assign a_use = a_sync[1];
  assign b_use = b_sync[1];
`else
  assign a_use = a;
  assign b_use = b;
`endif

  state_e           state;
  state_e           state_n;
  logic [WIN_W-1:0] timer;
  logic [WIN_W-1:0] timer_n;
  logic             a_q;
  logic             edge_c;
  logic             pass_n;
  logic             fail_n;

  // Edge detection and window FSM next-state / pulse decode.
  always_comb begin
    edge_c  = en & edge_hit(mode_e'(mode), a_use, a_q);
    state_n = state;
    timer_n = timer;
    pass_n  = 1'b0;
    fail_n  = 1'b0;
    if (!en) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (edge_c) begin
            if (b_use) begin
              pass_n = 1'b1;
            end else if (win == '0) begin
              fail_n = 1'b1;
            end else begin
              state_n = ST_WAIT;
              timer_n = win;
            end
          end
        end
        ST_WAIT: begin
          if (b_use) begin
            pass_n  = 1'b1;
            state_n = ST_IDLE;
          end else if (timer == WIN_W'(1)) begin
            fail_n  = 1'b1;
            state_n = ST_IDLE;
          end else begin
            timer_n = timer - WIN_W'(1);
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // State, timer, history and registered pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      timer  <= '0;
      a_q    <= 1'b0;
      edge_o <= 1'b0;
      pass_o <= 1'b0;
      fail_o <= 1'b0;
    end else begin
      state  <= state_n;
      timer  <= timer_n;
      a_q    <= a_use;
      edge_o <= edge_c;
      pass_o <= pass_n;
      fail_o <= fail_n;
    end
  end

  // Saturating edge counter; clear wins over a same-cycle edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_o <= '0;
    end else if (clr) begin
      cnt_o <= '0;
    end else if (edge_c && (cnt_o != '1)) begin
      cnt_o <= cnt_o + CNT_W'(1);
    end
  end

  assign busy_o = (state == ST_WAIT);

endmodule

// File: rtl/edge_seq_monitor.sv
// Multi-channel edge/sequence monitor: replicates one channel per bit of
// a/b, fans out shared controls and packs the per-channel counters.
// EDGE_SEQ_MONITOR_SYNC_EN: enables input synchronisers in each channel.
import edge_seq_monitor_pkg::*;

module edge_seq_monitor #(
  parameter int unsigned N_CH  = DEF_N_CH,
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned WIN_W = DEF_WIN_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [WIN_W-1:0]      win,
  input  logic                  clr,
  input  logic [N_CH-1:0]       a,
  input  logic [N_CH-1:0]       b,
  output logic [N_CH-1:0]       edge_o,
  output logic [N_CH-1:0]       pass_o,
  output logic [N_CH-1:0]       fail_o,
  output logic [N_CH-1:0]       busy_o,
  output logic [N_CH*CNT_W-1:0] cnt_o
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_seq_monitor_ch #(
      .CNT_W (CNT_W),
      .WIN_W (WIN_W)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .mode   (mode),
      .win    (win),
      .clr    (clr),
      .a      (a[i]),
      .b      (b[i]),
      .edge_o (edge_o[i]),
      .pass_o (pass_o[i]),
      .fail_o (fail_o[i]),
      .busy_o (busy_o[i]),
      .cnt_o  (cnt_o[i*CNT_W +: CNT_W])
    );
  end

endmodule
